// File: rtl/control_sequencer_if.sv
// Control bundle between the MiniSRC control sequencer and its datapath.
// The sequencer uses the master modport and the datapath uses the slave modport.
interface control_sequencer_if #(
  parameter int RETIRE_W = 16
);
  logic [31:0]         iInstr;
  logic                iCond;
  logic                iMemReady;
  logic                oIrEn;
  logic                oRaEn;
  logic                oRbEn;
  logic                oRmEn;
  logic                oRz0En;
  logic                oRz1En;
  logic                oRyEn;
  logic                oRfWrite;
  logic                oMbSel;
  logic [1:0]          oMySel;
  logic [1:0]          oMcSel;
  logic [3:0]          oAluCtl;
  logic                oPcInc;
  logic                oPcLoad;
  logic                oMemRead;
  logic                oMemWrite;
  logic                oDone;
  logic                oHalt;
  logic                oFault;
  logic [RETIRE_W-1:0] oRetired;

  modport master (
    input  iInstr, iCond, iMemReady,
    output oIrEn, oRaEn, oRbEn, oRmEn, oRz0En, oRz1En, oRyEn, oRfWrite,
           oMbSel, oMySel, oMcSel, oAluCtl, oPcInc, oPcLoad,
           oMemRead, oMemWrite, oDone, oHalt, oFault, oRetired
  );

  modport slave (
    output iInstr, iCond, iMemReady,
    input  oIrEn, oRaEn, oRbEn, oRmEn, oRz0En, oRz1En, oRyEn, oRfWrite,
           oMbSel, oMySel, oMcSel, oAluCtl, oPcInc, oPcLoad,
           oMemRead, oMemWrite, oDone, oHalt, oFault, oRetired
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle MiniSRC control FSM: fetch/decode/exec/mem/select/write sequencing,
// datapath strobes decoded from state plus latched opcode, and a retire counter.
module control_sequencer #(
  parameter int MULDIV_CYCLES = 4,
  parameter int RETIRE_W      = 16
) (
  input  logic         iClk,
  input  logic         iRst,
  control_sequencer_if.master bus
);
  localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_SELY, S_WRITE, S_HALT
  } state_e;

  typedef enum logic [4:0] {
    OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
    OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
    OP_OR   = 5'b00110, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101,
    OP_ORI  = 5'b01110, OP_DIV  = 5'b01111, OP_MUL  = 5'b10000,
    OP_BR   = 5'b10010, OP_JAL  = 5'b10101, OP_NOP  = 5'b11010,
    OP_HALT = 5'b11011
  } opcode_e;

  function automatic logic op_defined(input logic [4:0] op);
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI,
      OP_ORI, OP_DIV, OP_MUL, OP_BR, OP_JAL, OP_NOP, OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  state_e              r_state;
  logic [4:0]          r_opcode;
  logic [CNT_W-1:0]    r_cnt;
  logic [RETIRE_W-1:0] r_retired;
  logic                r_halt;
  logic                r_fault;

  logic [4:0] w_dec_op;
  logic       w_muldiv;
  logic       w_cnt_last;
  logic       w_done;
  logic [3:0] w_alu;
  logic       w_mb;
  logic [1:0] w_my;

  assign w_dec_op   = bus.iInstr[31:27];
  assign w_muldiv   = (r_opcode == OP_MUL) || (r_opcode == OP_DIV);
  assign w_cnt_last = (r_cnt == CNT_W'(MULDIV_CYCLES - 1));
  assign w_done     = ((r_state == S_EXEC) && (r_opcode == OP_BR)) ||
                      ((r_state == S_MEM) && (r_opcode == OP_ST) && bus.iMemReady) ||
                      (r_state == S_WRITE);

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_alu = 4'd0;
    w_mb  = 1'b0;
    w_my  = 2'd1;
    case (r_opcode)
      OP_LD:                  begin w_mb = 1'b1; w_my = 2'd2; end
      OP_LDI, OP_ST, OP_ADDI: w_mb = 1'b1;
      OP_SUB, OP_BR:          w_alu = 4'd1;
      OP_AND:                 w_alu = 4'd3;
      OP_OR:                  w_alu = 4'd2;
      OP_ANDI:                begin w_alu = 4'd3; w_mb = 1'b1; end
      OP_ORI:                 begin w_alu = 4'd2; w_mb = 1'b1; end
      OP_DIV:                 w_alu = 4'd4;
      OP_MUL:                 w_alu = 4'd5;
      OP_JAL:                 w_my = 2'd3;
      default:                ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state   <= S_FETCH;
      r_opcode  <= '0;
      r_cnt     <= '0;
      r_retired <= '0;
      r_halt    <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      if (w_done) r_retired <= r_retired + 1'b1;
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          r_opcode <= w_dec_op;
          if (w_dec_op == OP_NOP) begin
            r_state <= S_FETCH;
          end else if ((w_dec_op == OP_HALT) || !op_defined(w_dec_op)) begin
            r_state <= S_HALT;
            r_halt  <= 1'b1;
            r_fault <= !op_defined(w_dec_op);
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_muldiv && !w_cnt_last) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
            if (r_opcode == OP_BR)                             r_state <= S_FETCH;
            else if ((r_opcode == OP_LD) || (r_opcode == OP_ST)) r_state <= S_MEM;
            else                                               r_state <= S_SELY;
          end
        end
        S_MEM:   if (bus.iMemReady) r_state <= (r_opcode == OP_ST) ? S_FETCH : S_SELY;
        S_SELY:  r_state <= S_WRITE;
        S_WRITE: r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Strobes are gated by iRst so a reset aborts any pending write at once.
  always_comb begin
    bus.oIrEn     = 1'b0;
    bus.oRaEn     = 1'b0;
    bus.oRbEn     = 1'b0;
    bus.oRmEn     = 1'b0;
    bus.oRz0En    = 1'b0;
    bus.oRz1En    = 1'b0;
    bus.oRyEn     = 1'b0;
    bus.oRfWrite  = 1'b0;
    bus.oMbSel    = 1'b0;
    bus.oMySel    = 2'd0;
    bus.oMcSel    = 2'd0;
    bus.oAluCtl   = 4'd0;
    bus.oPcInc    = 1'b0;
    bus.oPcLoad   = 1'b0;
    bus.oMemRead  = 1'b0;
    bus.oMemWrite = 1'b0;
    bus.oDone     = 1'b0;
    if (!iRst) begin
      bus.oDone = w_done;
      case (r_state)
        S_FETCH:  begin bus.oIrEn = 1'b1; bus.oPcInc = 1'b1; end
        S_DECODE: begin bus.oRaEn = 1'b1; bus.oRbEn = 1'b1; end
        S_EXEC: begin
          bus.oAluCtl = w_alu;
          bus.oMbSel  = w_mb;
          bus.oRz0En  = !w_muldiv || w_cnt_last;
          bus.oRz1En  = !w_muldiv || w_cnt_last;
          bus.oRmEn   = (r_opcode == OP_ST);
          bus.oPcLoad = (r_opcode == OP_BR) ? bus.iCond : (r_opcode == OP_JAL);
        end
        S_MEM: begin
          bus.oMemRead  = (r_opcode == OP_LD);
          bus.oMemWrite = (r_opcode == OP_ST);
        end
        S_SELY:  begin bus.oMySel = w_my; bus.oRyEn = 1'b1; end
        S_WRITE: begin
          bus.oMySel   = w_my;
          bus.oRfWrite = 1'b1;
          bus.oMcSel   = (r_opcode == OP_JAL) ? 2'd2 : 2'd0;
        end
        default: ;
      endcase
    end
  end

  assign bus.oHalt    = r_halt;
  assign bus.oFault   = r_fault;
  assign bus.oRetired = r_retired;
endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer: a driver feeds instructions at
// each fetch and queues expected per-instruction behaviour; a monitor checks each retire.
module tb_control_sequencer;
  localparam int MULDIV_CYCLES = 4;
  localparam int RETIRE_W      = 16;

  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010,
                         OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101,
                         OP_OR = 5'b00110, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101,
                         OP_ORI = 5'b01110, OP_DIV = 5'b01111, OP_MUL = 5'b10000,
                         OP_BR = 5'b10010, OP_JAL = 5'b10101, OP_NOP = 5'b11010,
                         OP_HALT = 5'b11011, OP_BAD = 5'b11111;

  typedef struct {
    logic [4:0] op;
    logic       cond;
    int         wait_cyc;
  } stim_t;

  typedef struct {
    logic [4:0] op;
    int lat; int rf; int pcl; int mr; int mw; int rm; int rz;
    bit chk_alu; int alu; bit chk_mb; int mb; int my; int mc; int ret;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  control_sequencer_if #(.RETIRE_W(RETIRE_W)) bus();

  control_sequencer #(.MULDIV_CYCLES(MULDIV_CYCLES), .RETIRE_W(RETIRE_W)) dut (
    .iClk(clk),
    .iRst(rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    model_ret = 0;
  int    cur_wait = 0;
  int    mem_cnt = 0;

  logic [4:0] rand_ops [15] = '{OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
                                OP_ADDI, OP_ANDI, OP_ORI, OP_DIV, OP_MUL, OP_BR,
                                OP_JAL, OP_NOP};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the opcode table and latency rules.
  function automatic exp_t build_exp(input stim_t s, input int ret);
    exp_t e;
    e = '{op: s.op, lat: 5, rf: 1, pcl: 0, mr: 0, mw: 0, rm: 0, rz: 1,
          chk_alu: 1'b1, alu: 0, chk_mb: 1'b1, mb: 1, my: 1, mc: 0, ret: ret};
    case (s.op)
      OP_LD:   begin e.my = 2; e.lat = 6 + s.wait_cyc; e.mr = s.wait_cyc + 1; end
      OP_ST:   begin e.rf = 0; e.rm = 1; e.lat = 4 + s.wait_cyc; e.mw = s.wait_cyc + 1; end
      OP_ADD:  e.mb = 0;
      OP_SUB:  begin e.mb = 0; e.alu = 1; end
      OP_AND:  begin e.mb = 0; e.alu = 3; end
      OP_OR:   begin e.mb = 0; e.alu = 2; end
      OP_ANDI: e.alu = 3;
      OP_ORI:  e.alu = 2;
      OP_DIV:  begin e.mb = 0; e.alu = 4; e.lat = 4 + MULDIV_CYCLES; end
      OP_MUL:  begin e.mb = 0; e.alu = 5; e.lat = 4 + MULDIV_CYCLES; end
      OP_BR:   begin e.alu = 1; e.chk_mb = 1'b0; e.rf = 0; e.pcl = int'(s.cond); e.lat = 3; end
      OP_JAL:  begin e.chk_alu = 1'b0; e.chk_mb = 1'b0; e.pcl = 1; e.my = 3; e.mc = 2; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic bit retires(input logic [4:0] op);
    foreach (rand_ops[i]) if (rand_ops[i] == op && op != OP_NOP) return 1'b1;
    return 1'b0;
  endfunction

  // Driver: place the next instruction on the IR bus during each fetch cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.oIrEn) begin
        stim_t s;
        if (stim_q.size() != 0) s = stim_q.pop_front();
        else                    s = '{OP_NOP, 1'b0, 0};
        bus.iInstr = {s.op, 27'($urandom)};
        bus.iCond  = s.cond;
        cur_wait   = s.wait_cyc;
        if (retires(s.op)) begin
          model_ret++;
          exp_q.push_back(build_exp(s, model_ret % (2 ** RETIRE_W)));
        end
      end
    end
  end

  // Memory responder: ready after cur_wait strobe cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (bus.oMemRead || bus.oMemWrite)) begin
        bus.iMemReady = (mem_cnt == cur_wait);
        mem_cnt++;
      end else begin
        bus.iMemReady = 1'b0;
        mem_cnt = 0;
      end
    end
  end

  // Monitor: accumulate what the DUT did since fetch, compare on each retire.
  int   cyc, rf, pcl, mr, mw, rm, rz0, rz1, alu, mb, my_y, my_w, mc, ret_exp;
  bit   active, ret_pend;
  exp_t e;
  initial begin
    active = 1'b0;
    ret_pend = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        active = 1'b0;
        ret_pend = 1'b0;
      end else begin
        if (ret_pend) begin
          check("retired_count", 32'(bus.oRetired), ret_exp);
          ret_pend = 1'b0;
        end
        if (bus.oIrEn) begin
          active = 1'b1;
          cyc = 0; rf = 0; pcl = 0; mr = 0; mw = 0; rm = 0; rz0 = 0; rz1 = 0;
          alu = -1; mb = -1; my_y = -1; my_w = -1; mc = -1;
        end
        if (active) begin
          cyc++;
          if (bus.oRz0En)   begin rz0++; alu = int'(bus.oAluCtl); mb = int'(bus.oMbSel); end
          if (bus.oRz1En)   rz1++;
          if (bus.oPcLoad)  pcl++;
          if (bus.oMemRead) mr++;
          if (bus.oMemWrite) mw++;
          if (bus.oRmEn)    rm++;
          if (bus.oRyEn)    my_y = int'(bus.oMySel);
          if (bus.oRfWrite) begin rf++; my_w = int'(bus.oMySel); mc = int'(bus.oMcSel); end
        end
        if (bus.oDone) begin
          if (!active || exp_q.size() == 0) begin
            check("unexpected_done", exp_q.size(), 32'(1));
          end else begin
            e = exp_q.pop_front();
            check($sformatf("latency_op%05b", e.op), cyc, e.lat);
            check($sformatf("rfwrite_op%05b", e.op), rf, e.rf);
            check($sformatf("pcload_op%05b", e.op), pcl, e.pcl);
            check($sformatf("memread_op%05b", e.op), mr, e.mr);
            check($sformatf("memwrite_op%05b", e.op), mw, e.mw);
            check($sformatf("rmen_op%05b", e.op), rm, e.rm);
            check($sformatf("rz0_op%05b", e.op), rz0, e.rz);
            check($sformatf("rz1_op%05b", e.op), rz1, e.rz);
            if (e.chk_alu) check($sformatf("aluctl_op%05b", e.op), alu, e.alu);
            if (e.chk_mb)  check($sformatf("mbsel_op%05b", e.op), mb, e.mb);
            if (e.rf != 0) begin
              check($sformatf("mysel_sely_op%05b", e.op), my_y, e.my);
              check($sformatf("mysel_write_op%05b", e.op), my_w, e.my);
              check($sformatf("mcsel_op%05b", e.op), mc, e.mc);
            end
            ret_pend = 1'b1;
            ret_exp  = e.ret;
          end
          active = 1'b0;
        end
      end
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < 20000), 32'(1));
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!bus.oHalt && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.oHalt), 32'(1));
  endtask

  task automatic do_reset(input string name);
    @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    model_ret = 0;
    #1;
    check({name, "_halt_clr"}, 32'(bus.oHalt), 32'(0));
    check({name, "_fault_clr"}, 32'(bus.oFault), 32'(0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check({name, "_fetch"}, 32'(bus.oIrEn), 32'(1));
    check({name, "_retired"}, 32'(bus.oRetired), 32'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.iInstr = '0;
    bus.iCond = 1'b0;
    bus.iMemReady = 1'b0;
    #2;
    check("rst_outputs", {bus.oIrEn, bus.oPcInc, bus.oRfWrite, bus.oMemWrite,
                          bus.oMemRead, bus.oDone, bus.oRaEn}, 32'(0));
    repeat (3) @(posedge clk);
    #1;
    check("rst_halt", 32'(bus.oHalt), 32'(0));
    check("rst_fault", 32'(bus.oFault), 32'(0));
    check("rst_retired", 32'(bus.oRetired), 32'(0));
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("fetch_after_rst_iren", 32'(bus.oIrEn), 32'(1));
    check("fetch_after_rst_pcinc", 32'(bus.oPcInc), 32'(1));

    stim_q.push_back('{OP_ADD, 1'b0, 0});
    stim_q.push_back('{OP_LD, 1'b0, 3});
    stim_q.push_back('{OP_MUL, 1'b0, 0});
    stim_q.push_back('{OP_BR, 1'b1, 0});
    stim_q.push_back('{OP_BR, 1'b0, 0});
    stim_q.push_back('{OP_NOP, 1'b0, 0});
    stim_q.push_back('{OP_JAL, 1'b0, 0});
    stim_q.push_back('{OP_ST, 1'b0, 0});
    stim_q.push_back('{OP_ST, 1'b0, 2});
    stim_q.push_back('{OP_LD, 1'b0, 0});
    foreach (rand_ops[i]) stim_q.push_back('{rand_ops[i], 1'($urandom), 1});
    for (int i = 0; i < 150; i++) begin
      stim_q.push_back('{rand_ops[$urandom_range(14, 0)], 1'($urandom), int'($urandom_range(4, 0))});
    end
    drain("drain_main");

    stim_q.push_back('{OP_BAD, 1'b0, 0});
    wait_halt("fault_halt_reached");
    #2;
    check("fault_flag", 32'(bus.oFault), 32'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("halt_iren", 32'(bus.oIrEn), 32'(0));
      check("halt_strobes", {bus.oPcInc, bus.oPcLoad, bus.oRfWrite, bus.oMemRead,
                             bus.oMemWrite, bus.oDone, bus.oRaEn, bus.oRz0En}, 32'(0));
      check("halt_held", 32'(bus.oHalt), 32'(1));
    end
    do_reset("fault_rst");

    stim_q.push_back('{OP_HALT, 1'b0, 0});
    wait_halt("halt_op_reached");
    #2;
    check("halt_op_no_fault", 32'(bus.oFault), 32'(0));
    do_reset("halt_rst");

    stim_q.push_back('{OP_ST, 1'b0, 50});
    n = 0;
    while (!bus.oMemWrite && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("st_mem_reached", 32'(bus.oMemWrite), 32'(1));
    #2 rst = 1'b1;
    exp_q.delete();
    model_ret = 0;
    #1;
    check("st_rst_memwrite_drop", 32'(bus.oMemWrite), 32'(0));
    check("st_rst_no_rfwrite", 32'(bus.oRfWrite), 32'(0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("st_rst_fetch", 32'(bus.oIrEn), 32'(1));
    check("st_rst_retired", 32'(bus.oRetired), 32'(0));

    stim_q.push_back('{OP_ADDI, 1'b0, 0});
    stim_q.push_back('{OP_DIV, 1'b0, 0});
    drain("drain_post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle control FSM for the MiniSRC processor; sits directly upstream of the datapath and drives every register enable, mux select, ALU opcode and register-file write strobe.
- Consumes the IR contents and the ALU branch condition, sequences fetch / decode / execute / memory / writeback, and handshakes with data memory.
- Also produces PC update strobes and a retired-instruction counter for bring-up and verification.

Parameters:
- MULDIV_CYCLES, 4, number of cycles EXEC holds for mul/div (≥1).
- RETIRE_W, 16, width of the retired-instruction counter.

Ports:
- iClk  in  1  system clock.
- iRst  in  1  asynchronous active-high reset.
- iInstr  in  32  IR output; opcode is [31:27].
- iCond  in  1  ALU branch condition, valid in EXEC.
- iMemReady  in  1  data memory done; sampled in MEM.
- oIrEn, oRaEn, oRbEn, oRmEn, oRz0En, oRz1En, oRyEn  out  1 each  datapath register enables.
- oRfWrite  out  1  register-file write.
- oMbSel  out  1  0 = RB, 1 = immediate.
- oMySel  out  2  0 = rz1, 1 = rz0, 2 = memory, 3 = return address.
- oMcSel  out  2  write address: 0 = Ra field, 1 = Rb field, 2 = link reg, 3 = zero.
- oAluCtl  out  4  0 add, 1 sub, 2 or, 3 and, 4 div, 5 mul.
- oPcInc  out  1  PC += 4.
- oPcLoad  out  1  PC load target.
- oMemRead, oMemWrite  out  1 each  data memory strobes.
- oDone  out  1  one-cycle pulse when an instruction retires.
- oHalt  out  1  processor stopped.
- oFault  out  1  illegal opcode seen.
- oRetired  out  RETIRE_W  retired-instruction count.

Behaviour:
- Reset: state = FETCH, opcode latch = 0, muldiv counter = 0, oRetired = 0, oHalt = 0, oFault = 0.
  - All other outputs are 0 while iRst is high.
  - Reset mid-instruction aborts it: no rf write or memory write occurs after reset assertion.
- States: FETCH, DECODE, EXEC, MEM, SELY, WRITE, HALT. Outputs are a Moore decode of state plus the latched opcode.
- FETCH:
  - oIrEn = 1, oPcInc = 1.
  - Next state is DECODE.
- DECODE:
  - Latch iInstr[31:27] into the opcode register.
  - oRaEn = oRbEn = 1.
  - Next state by opcode:
    - nop → FETCH.
    - halt → HALT.
    - undefined opcode → HALT with oFault = 1.
    - otherwise → EXEC.
- Opcode table:
  - 00000 ld: add, mb = 1, goes through MEM, my = 2.
  - 00001 ldi: add, mb = 1, my = 1.
  - 00010 st: add, mb = 1; oRmEn = 1 in EXEC; MEM with write; no WRITE.
  - 00011 add / 00100 sub / 00101 and / 00110 or: ALU 0/1/3/2, mb = 0, my = 1.
  - 01100 addi / 01101 andi / 01110 ori: ALU 0/3/2, mb = 1, my = 1.
  - 01111 div / 10000 mul: ALU 4/5, mb = 0, multi-cycle, my = 1.
  - 10010 br: ALU sub; no writeback.
  - 10101 jal: oPcLoad in EXEC, my = 3, mc = 2.
  - 11010 nop.
  - 11011 halt.
  - All other codes are undefined.
- EXEC:
  - oAluCtl and oMbSel are driven from the opcode; oRz0En = oRz1En = 1.
  - mul/div: stay in EXEC until the counter reaches MULDIV_CYCLES−1. Rz enables are asserted only on the final cycle. The counter clears on exit.
  - br: oPcLoad = iCond; → FETCH and retire.
  - ld/st → MEM. All other opcodes → SELY.
- MEM:
  - oMemRead (ld) or oMemWrite (st) is held continuously until the cycle iMemReady = 1.
  - On that cycle: ld → SELY; st → FETCH and retire. No timeout.
- SELY:
  - oMySel per the opcode table; oRyEn = 1; → WRITE.
- WRITE:
  - oRfWrite = 1; oMcSel = 2 for jal, else 0; oMySel is held.
  - → FETCH and retire.
- Retire:
  - oDone pulses for exactly one cycle, in the last cycle of the instruction.
  - oRetired increments on that edge and wraps to 0 from all-ones.
- HALT:
  - All enables and strobes are 0; oHalt = 1; oFault is sticky.
  - Only iRst exits HALT.
- Latency in cycles, FETCH to oDone inclusive:
  - ALU op: 5.
  - ld: 6 + memory wait cycles.
  - st: 4 + memory wait cycles.
  - mul/div: 4 + MULDIV_CYCLES.
  - br: 3.
  - nop: 2 (no oDone, not counted).

Test Plan:
- Reset, then add (opcode 00011) → states FETCH, DECODE, EXEC, SELY, WRITE:
  - oAluCtl = 0 in EXEC; oMySel = 1 in SELY.
  - oRfWrite high in cycle 5; oRetired = 1.
- ld with iMemReady delayed 3 cycles:
  - oMemRead is held for 4 cycles.
  - oMySel = 2 in SELY; oDone in cycle 9.
- mul with MULDIV_CYCLES = 4:
  - EXEC lasts 4 cycles; oRz0En only in the 4th.
  - oDone at cycle 8.
- br with iCond = 1, then iCond = 0:
  - oPcLoad = 1 in EXEC only for the first; both retire in 3 cycles.
  - No oRfWrite for either.
- Opcode 11111:
  - HALT after DECODE; oFault = 1, oHalt = 1.
  - oIrEn stays 0 for 10 cycles; iRst clears both flags.
- iRst asserted during MEM of st:
  - oMemWrite drops immediately (asynchronously).
  - FETCH is the state after release; oRetired = 0.
